// File: rtl/sprite_fetch_if.sv
// Bundle of the request, RAM and pixel-stream signals around sprite_fetch.
// Both valid/ready pairs behave the same way: a transfer happens on a rising
// clock edge where valid && ready are both high. The sender holds valid and its
// payload stable until that transfer, and ready never depends on a later valid.
// The RAM pair has no handshake: ram_data belongs to the ram_addr that was
// presented one cycle earlier.
interface sprite_fetch_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 5
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ID_W-1:0]   req_id;
  logic              req_flip;
  logic [ADDR_W-1:0] ram_addr;
  logic [PIX_W-1:0]  ram_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data;
  logic [3:0]        pix_x;
  logic [3:0]        pix_y;
  logic              pix_transp;
  logic              pix_last;

  // Environment side: draw scheduler, frame RAM and compositor.
  modport master (
    output req_valid, req_id, req_flip, ram_data, pix_ready,
    input  req_ready, ram_addr, pix_valid, pix_data, pix_x, pix_y,
           pix_transp, pix_last
  );

  // Engine side.
  modport slave (
    input  req_valid, req_id, req_flip, ram_data, pix_ready,
    output req_ready, ram_addr, pix_valid, pix_data, pix_x, pix_y,
           pix_transp, pix_last
  );
endinterface

// File: rtl/sprite_fetch.sv
// Sprite fetch engine: walks one SPR_W x SPR_H tile of the sprite sheet,
// issues RAM reads, absorbs the 1-cycle RAM latency and streams the pixels in
// raster order through a 2-entry skid buffer with valid/ready backpressure.
module sprite_fetch #(
  parameter int SHEET_W     = 20,
  parameter int SPR_W       = 10,
  parameter int SPR_H       = 10,
  parameter int SPR_PER_ROW = 2,
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 19,
  parameter int PIX_W       = 5
) (
  input  logic          clk,
  input  logic          rst,
  sprite_fetch_if.slave bus,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] LAST_X = 4'(SPR_W - 1);
  localparam logic [3:0] LAST_Y = 4'(SPR_H - 1);

  state_t            state_q, state_d;
  logic              flip_q, flip_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        x_q, x_d;
  logic [3:0]        y_q, y_d;

  // Tags of the read currently inside the RAM pipeline.
  logic              infl_q, infl_d;
  logic [3:0]        infl_x_q, infl_x_d;
  logic [3:0]        infl_y_q, infl_y_d;
  logic              infl_last_q, infl_last_d;

  // Two-entry output buffer.
  logic [PIX_W-1:0]  buf_data_q [2];
  logic [PIX_W-1:0]  buf_data_d [2];
  logic [3:0]        buf_x_q [2];
  logic [3:0]        buf_x_d [2];
  logic [3:0]        buf_y_q [2];
  logic [3:0]        buf_y_d [2];
  logic              buf_last_q [2];
  logic              buf_last_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              push, pop, issue, room, req_ready_c;
  logic [2:0]        occ_after;
  logic [ADDR_W-1:0] id_row, id_col, xs;

  // Start address of the requested sprite inside the sheet.
  assign id_row = ADDR_W'(bus.req_id / ID_W'(SPR_PER_ROW));
  assign id_col = ADDR_W'(bus.req_id % ID_W'(SPR_PER_ROW));

  // Sheet column of the current read; flipped sprites read right to left.
  assign xs = flip_q ? (ADDR_W'(SPR_W - 1) - ADDR_W'(x_q)) : ADDR_W'(x_q);
  assign bus.ram_addr = base_q + ADDR_W'(y_q) * ADDR_W'(SHEET_W) + xs;

  // Buffer occupancy: one landing read pushes, an accepted head pops.
  always_comb begin
    push = infl_q;
    pop  = (count_q != 2'd0) && bus.pix_ready;
    buf_data_d = buf_data_q;
    buf_x_d    = buf_x_q;
    buf_y_d    = buf_y_q;
    buf_last_d = buf_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      buf_data_d[wr_ptr_q] = bus.ram_data;
      buf_x_d[wr_ptr_q]    = infl_x_q;
      buf_y_d[wr_ptr_q]    = infl_y_q;
      buf_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // A read may issue only if its pixel is guaranteed a buffer slot on landing.
  always_comb begin
    occ_after = 3'(count_q) + 3'(infl_q) - 3'(pop);
    room      = (occ_after < 3'd2);
  end

  // Engine FSM: accept a request, walk the tile, then wait for the pipe to empty.
  always_comb begin
    state_d     = state_q;
    flip_d      = flip_q;
    base_d      = base_q;
    x_d         = x_q;
    y_d         = y_q;
    issue       = 1'b0;
    req_ready_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          flip_d  = bus.req_flip;
          base_d  = id_row * ADDR_W'(SPR_H * SHEET_W) + id_col * ADDR_W'(SPR_W);
          x_d     = 4'd0;
          y_d     = 4'd0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (room) begin
          issue = 1'b1;
          if (x_q == LAST_X) begin
            x_d = 4'd0;
            if (y_q == LAST_Y) state_d = DRAIN;
            else               y_d = y_q + 4'd1;
          end else begin
            x_d = x_q + 4'd1;
          end
        end
      end
      DRAIN: begin
        // Leaving on the final pop lets req_ready rise the very next cycle.
        if (!infl_q && count_d == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tags travel alongside the read so the buffer entry knows its position.
  always_comb begin
    infl_d      = issue;
    infl_x_d    = issue ? x_q : infl_x_q;
    infl_y_d    = issue ? y_q : infl_y_q;
    infl_last_d = issue ? (x_q == LAST_X && y_q == LAST_Y) : infl_last_q;
  end

  // State registers; reset aborts any sprite in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flip_q      <= 1'b0;
      base_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      infl_q      <= 1'b0;
      infl_x_q    <= '0;
      infl_y_q    <= '0;
      infl_last_q <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_x_q[i]    <= '0;
        buf_y_q[i]    <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      flip_q      <= flip_d;
      base_q      <= base_d;
      x_q         <= x_d;
      y_q         <= y_d;
      infl_q      <= infl_d;
      infl_x_q    <= infl_x_d;
      infl_y_q    <= infl_y_d;
      infl_last_q <= infl_last_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      buf_data_q  <= buf_data_d;
      buf_x_q     <= buf_x_d;
      buf_y_q     <= buf_y_d;
      buf_last_q  <= buf_last_d;
    end
  end

  // Head of the buffer drives the pixel port; fields read zero while empty.
  assign bus.req_ready  = req_ready_c;
  assign bus.pix_valid  = (count_q != 2'd0);
  assign bus.pix_data   = bus.pix_valid ? buf_data_q[rd_ptr_q] : '0;
  assign bus.pix_x      = bus.pix_valid ? buf_x_q[rd_ptr_q]    : 4'd0;
  assign bus.pix_y      = bus.pix_valid ? buf_y_q[rd_ptr_q]    : 4'd0;
  assign bus.pix_last   = bus.pix_valid && buf_last_q[rd_ptr_q];
  assign bus.pix_transp = bus.pix_valid && (buf_data_q[rd_ptr_q] == '0);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Bench for sprite_fetch: frame RAM model, sprite-sheet reference model,
// directed and randomized draw requests with varying compositor readiness.
module tb_sprite_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;

  logic [4:0]  sheet [1024];
  logic [14:0] exp_q[$];
  logic [18:0] addr_q[$];

  sprite_fetch_if bus ();

  sprite_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and registered-read frame RAM.
  always #5 clk = ~clk;
  always @(posedge clk) bus.ram_data <= sheet[bus.ram_addr[9:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] head();
    return {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_transp, bus.pix_last};
  endfunction

  // Expected raster stream of one sprite straight from the sheet geometry.
  task automatic model_build(input int id, input bit flip);
    int base, addr, col;
    logic [4:0] d;
    exp_q.delete();
    addr_q.delete();
    base = (id / 2) * 10 * 20 + (id % 2) * 10;
    for (int y = 0; y < 10; y++) begin
      for (int x = 0; x < 10; x++) begin
        col  = flip ? 9 - x : x;
        addr = base + y * 20 + col;
        d    = sheet[addr];
        addr_q.push_back(19'(addr));
        exp_q.push_back({d, 4'(x), 4'(y), (d == 5'd0), (x == 9 && y == 9)});
      end
    end
  endtask

  // Present a request and hold it until accepted; returns at posedge+1.
  task automatic accept(input int id, input bit flip, input bit strict);
    int w = 0;
    model_build(id, flip);
    bus.req_valid = 1'b1;
    bus.req_id    = 4'(id);
    bus.req_flip  = flip;
    @(negedge clk);
    if (strict) chk("req_ready_after_last", bus.req_ready, 1);
    while (!bus.req_ready && w < 500) begin
      @(posedge clk); #1;
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) chk("accept_timeout", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // mode 0: ready high; 1: stall 5 cycles after pixel 13 then random; 2: random.
  task automatic run_stream(input int mode, input int max_pix);
    int got = 0, cyc = 0, stall = 0, first = -1, last = -1;
    while (got < max_pix && cyc < 3000) begin
      case (mode)
        0: bus.pix_ready = 1'b1;
        1: begin
          if (got < 13) bus.pix_ready = 1'b1;
          else if (stall < 5) begin bus.pix_ready = 1'b0; stall++; end
          else bus.pix_ready = 1'($urandom_range(0, 1));
        end
        default: bus.pix_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      chk("req_ready_busy", bus.req_ready, 0);
      if (mode == 0 && cyc < 100) chk("ram_addr", bus.ram_addr, addr_q[cyc]);
      if (bus.pix_valid) begin
        if (first < 0) first = cyc;
        if (exp_q.size() == 0) chk("extra_pixel", bus.pix_valid, 0);
        else begin
          chk("pixel", head(), exp_q[0]);
          if (bus.pix_ready) begin
            void'(exp_q.pop_front());
            got++;
            last = cyc;
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (got < max_pix) chk("stream_timeout", got, max_pix);
    if (mode == 0 && max_pix == 100) begin
      chk("first_latency", first, 2);
      chk("last_cycle", last, 101);
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ready", bus.req_ready, 1);
      chk("idle_valid", bus.pix_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      sheet[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_id    = '0;
    bus.req_flip  = 1'b0;
    bus.pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_pix_valid", bus.pix_valid, 0);
    chk("rst_pix_last", bus.pix_last, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_pix_fields", head(), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sprite 0, plain.
    accept(0, 1'b0, 1'b0);
    run_stream(0, 100);
    idle_check(2);

    // Sprite 3: second sheet row, right column.
    accept(3, 1'b0, 1'b0);
    run_stream(0, 100);
    idle_check(1);

    // Sprite 1 mirrored.
    accept(1, 1'b1, 1'b0);
    run_stream(0, 100);
    idle_check(1);

    // Backpressure: stall after pixel 13, then random readiness.
    accept(0, 1'b0, 1'b0);
    run_stream(1, 100);
    idle_check(3);

    // Reset in the middle of sprite 2, then a clean sprite 0.
    accept(2, 1'b0, 1'b0);
    run_stream(0, 40);
    rst = 1'b1;
    #1;
    chk("abort_pix_valid", bus.pix_valid, 0);
    chk("abort_req_ready", bus.req_ready, 1);
    chk("abort_ram_addr", bus.ram_addr, 0);
    chk("abort_pix_last", bus.pix_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    accept(0, 1'b0, 1'b0);
    run_stream(0, 100);

    // Back-to-back requests.
    accept(0, 1'b0, 1'b0);
    run_stream(0, 100);
    accept(1, 1'b0, 1'b1);
    run_stream(0, 100);
    idle_check(1);

    // Random sprites, random flip, random readiness.
    for (int k = 0; k < 4; k++) begin
      accept(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      run_stream(2, 100);
      idle_check(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
